// File: rtl/fase_noite.sv
// fase_noite: PoliLobinho night phase: polls living players, resolves wolf kill vs. doctor, reveals seer class,
// keeps the alive mask and declares the winner.
module fase_noite (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirma,
  input  logic [2:0] alvo,
  input  logic [9:0] jogo_atual,
  output logic       pronto,
  output logic       aguardando,
  output logic [2:0] jogador_atual,
  output logic       erro,
  output logic [4:0] vivos,
  output logic       morte_valida,
  output logic [2:0] morto,
  output logic       revela_valida,
  output logic [1:0] revela_classe,
  output logic       fim_noite,
  output logic [1:0] vencedor,
  output logic [3:0] db_estado
);
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    BUSCA    = 3'd1,
    ESPERA   = 3'd2,
    RESOLVE  = 3'd3,
    VERIFICA = 3'd4,
    FIM_JOGO = 3'd5
  } estado_t;
  estado_t estado, prox;
  logic [2:0] idx, lobo_alvo, medico_alvo, n_lobos, n_vila;
  logic lobo_valido, medico_valido, alvo_ok, matar;
  logic [15:0] classes;
  logic [7:0] vivos_ext;
  logic [1:0] classe_atual, classe_alvo, veredito;
  // zero-extended views let 3-bit indices reach 5..7 safely (they read as dead / aldeao)
  assign classes = {6'd0, jogo_atual};
  assign vivos_ext = {3'd0, vivos};
  assign classe_atual = classes[{idx, 1'b0} +: 2];
  assign classe_alvo = classes[{alvo, 1'b0} +: 2];
  assign alvo_ok = (alvo <= 3'd4) && vivos_ext[alvo];
  assign matar = lobo_valido && !(medico_valido && medico_alvo == lobo_alvo);
  assign veredito = n_lobos == 3'd0 ? 2'b01 : n_lobos >= n_vila ? 2'b10 : 2'b00;
  assign pronto = estado == OCIOSO;
  assign aguardando = estado == ESPERA;
  assign jogador_atual = idx;
  assign db_estado = {1'b0, estado};
  always_comb begin
    n_lobos = 3'd0;
    n_vila = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n_lobos = n_lobos + {2'd0, vivos[i] & (jogo_atual[2*i+:2] == 2'b01)};
      n_vila = n_vila + {2'd0, vivos[i] & (jogo_atual[2*i+:2] != 2'b01)};
    end
  end
  always_ff @(posedge clock) estado <= reset ? OCIOSO : prox;
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:   prox = iniciar ? BUSCA : OCIOSO;
      BUSCA:    prox = idx == 3'd5 ? RESOLVE : vivos_ext[idx] ? ESPERA : BUSCA;
      ESPERA:   prox = confirma && alvo_ok ? BUSCA : ESPERA;
      RESOLVE:  prox = VERIFICA;
      VERIFICA: prox = veredito != 2'b00 ? FIM_JOGO : OCIOSO;
      default:  prox = estado;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= 3'd0;
      lobo_alvo <= 3'd0;
      lobo_valido <= 1'b0;
      medico_alvo <= 3'd0;
      medico_valido <= 1'b0;
      erro <= 1'b0;
      vivos <= 5'b11111;
      morte_valida <= 1'b0;
      morto <= 3'd0;
      revela_valida <= 1'b0;
      revela_classe <= 2'b00;
      fim_noite <= 1'b0;
      vencedor <= 2'b00;
    end else begin
      erro <= estado == ESPERA && confirma && !alvo_ok;
      fim_noite <= estado == VERIFICA;
      case (estado)
        OCIOSO: if (iniciar) begin
          idx <= 3'd0;
          lobo_valido <= 1'b0;
          medico_valido <= 1'b0;
          revela_valida <= 1'b0;
        end
        BUSCA: if (idx != 3'd5 && !vivos_ext[idx]) idx <= idx + 3'd1;
        ESPERA: if (confirma && alvo_ok) begin
          idx <= idx + 3'd1;
          if (classe_atual == 2'b01) begin
            lobo_alvo <= alvo;
            lobo_valido <= 1'b1;
          end
          if (classe_atual == 2'b10) begin
            medico_alvo <= alvo;
            medico_valido <= 1'b1;
          end
          if (classe_atual == 2'b11) begin
            revela_classe <= classe_alvo;
            revela_valida <= 1'b1;
          end
        end
        RESOLVE: begin
          morte_valida <= matar;
          if (matar) begin
            vivos <= vivos & ~(5'b00001 << lobo_alvo);
            morto <= lobo_alvo;
          end
        end
        VERIFICA: vencedor <= veredito;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fase_noite.sv
// tb_fase_noite: table-driven nights with an end-of-night scoreboard for fase_noite.
module tb_fase_noite;
  logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, confirma = 1'b0;
  logic [2:0] alvo = 3'd0;
  logic [9:0] jogo_atual = 10'b00_00_11_10_01;
  logic pronto, aguardando, erro, morte_valida, revela_valida, fim_noite;
  logic [2:0] jogador_atual, morto;
  logic [4:0] vivos;
  logic [1:0] revela_classe, vencedor;
  logic [3:0] db_estado;

  fase_noite dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .confirma(confirma), .alvo(alvo),
    .jogo_atual(jogo_atual), .pronto(pronto), .aguardando(aguardando),
    .jogador_atual(jogador_atual), .erro(erro), .vivos(vivos), .morte_valida(morte_valida),
    .morto(morto), .revela_valida(revela_valida), .revela_classe(revela_classe),
    .fim_noite(fim_noite), .vencedor(vencedor), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {int noite; logic [2:0] alvo; int espera; logic [2:0] jog; logic erro;} passo_t;
  typedef struct {logic [4:0] vivos; logic mv; logic [2:0] morto; logic rv; logic [1:0] rc; logic [1:0] venc;} fim_t;
  passo_t passos[$];
  fim_t fins[6];
  fim_t sb[$];
  int cmp = 0, err = 0, pulsos = 0;

  task automatic chk(string n, int got, int exp);
    cmp++;
    if (got != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  task automatic ciclo;
    @(posedge clock);
    #1;
  endtask

  task automatic rst;
    reset = 1'b1;
    ciclo;
    reset = 1'b0;
  endtask

  task automatic confirmar(passo_t p);
    int w = 0;
    while (!aguardando && w < 10) begin
      ciclo;
      w++;
    end
    chk("latencia_espera", w, p.espera);
    chk("jogador_atual", jogador_atual, p.jog);
    alvo = p.alvo;
    confirma = 1'b1;
    ciclo;
    confirma = 1'b0;
    chk("erro", erro, p.erro);
    if (p.erro) begin
      chk("jogador_mantido", jogador_atual, p.jog);
      chk("espera_mantida", aguardando, 1);
    end
  endtask

  task automatic noite(int n, bit esperado);
    if (esperado) sb.push_back(fins[n]);
    iniciar = 1'b1;
    ciclo;
    iniciar = 1'b0;
    chk("busca_apos_iniciar", db_estado, 1);
    foreach (passos[i]) if (passos[i].noite == n) confirmar(passos[i]);
  endtask

  task automatic esperar_fim(int lat);
    int w = 0;
    while (!fim_noite && w < 10) begin
      ciclo;
      w++;
    end
    chk("fim_noite_chegou", fim_noite, 1);
    chk("latencia_fim", w, lat);
    ciclo;
    chk("fim_noite_pulso_unico", fim_noite, 0);
  endtask

  always @(negedge clock) if (fim_noite) begin
    fim_t e;
    pulsos++;
    if (sb.size() == 0) begin
      cmp++;
      err++;
      $display("FAIL fim_inesperado: fim_noite with no night pending at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("sb_vivos", vivos, e.vivos);
      chk("sb_morte_valida", morte_valida, e.mv);
      chk("sb_morto", morto, e.morto);
      chk("sb_revela_valida", revela_valida, e.rv);
      chk("sb_revela_classe", revela_classe, e.rc);
      chk("sb_vencedor", vencedor, e.venc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    passos = '{
      '{1, 3'd3, 1, 3'd0, 1'b0}, '{1, 3'd4, 1, 3'd1, 1'b0}, '{1, 3'd0, 1, 3'd2, 1'b0},
      '{1, 3'd0, 1, 3'd3, 1'b0}, '{1, 3'd0, 1, 3'd4, 1'b0},
      '{2, 3'd3, 1, 3'd0, 1'b1}, '{2, 3'd6, 0, 3'd0, 1'b1}, '{2, 3'd4, 0, 3'd0, 1'b0},
      '{2, 3'd2, 1, 3'd1, 1'b0}, '{2, 3'd1, 1, 3'd2, 1'b0}, '{2, 3'd0, 2, 3'd4, 1'b0},
      '{3, 3'd1, 1, 3'd0, 1'b0}, '{3, 3'd2, 1, 3'd1, 1'b0}, '{3, 3'd0, 1, 3'd2, 1'b0},
      '{4, 3'd4, 1, 3'd0, 1'b0}, '{4, 3'd4, 1, 3'd1, 1'b0}, '{4, 3'd1, 1, 3'd2, 1'b0},
      '{4, 3'd0, 1, 3'd3, 1'b0}, '{4, 3'd0, 1, 3'd4, 1'b0},
      '{5, 3'd0, 1, 3'd0, 1'b0}, '{5, 3'd2, 1, 3'd1, 1'b0}, '{5, 3'd3, 1, 3'd2, 1'b0},
      '{5, 3'd0, 1, 3'd3, 1'b0}, '{5, 3'd0, 1, 3'd4, 1'b0},
      '{6, 3'd1, 1, 3'd0, 1'b0}, '{6, 3'd1, 1, 3'd1, 1'b0}
    };
    fins[0] = '{5'b11111, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00};
    fins[1] = '{5'b10111, 1'b1, 3'd3, 1'b1, 2'b01, 2'b00};
    fins[2] = '{5'b00111, 1'b1, 3'd4, 1'b1, 2'b10, 2'b00};
    fins[3] = '{5'b00101, 1'b1, 3'd1, 1'b1, 2'b01, 2'b10};
    fins[4] = '{5'b11111, 1'b0, 3'd0, 1'b1, 2'b10, 2'b00};
    fins[5] = '{5'b11110, 1'b1, 3'd0, 1'b1, 2'b00, 2'b01};
    ciclo;
    reset = 1'b0;
    chk("rst_estado", db_estado, 0);
    chk("rst_pronto", pronto, 1);
    chk("rst_vivos", vivos, 5'b11111);
    chk("rst_aguardando", aguardando, 0);
    chk("rst_erro", erro, 0);
    chk("rst_fim_noite", fim_noite, 0);
    chk("rst_vencedor", vencedor, 0);
    chk("rst_morte_valida", morte_valida, 0);
    chk("rst_morto", morto, 0);
    chk("rst_revela_valida", revela_valida, 0);
    chk("rst_revela_classe", revela_classe, 0);
    chk("rst_jogador", jogador_atual, 0);
    alvo = 3'd7;
    confirma = 1'b1;
    ciclo;
    confirma = 1'b0;
    chk("confirma_ocioso_sem_erro", erro, 0);
    chk("confirma_ocioso_estado", db_estado, 0);
    // night 1: kill P3, exact end-of-night timing
    noite(1, 1'b1);
    chk("n1_busca_k1", db_estado, 1);
    ciclo;
    chk("n1_resolve_k2", db_estado, 3);
    ciclo;
    chk("n1_verifica_k3", db_estado, 4);
    chk("n1_vivos_k3", vivos, 5'b10111);
    ciclo;
    chk("n1_ocioso_k4", db_estado, 0);
    chk("n1_fim_k4", fim_noite, 1);
    ciclo;
    chk("n1_fim_pulso", fim_noite, 0);
    // nights 2 and 3: rejections, skip of dead P3, wolves win
    noite(2, 1'b1);
    esperar_fim(3);
    noite(3, 1'b1);
    esperar_fim(5);
    chk("fj_estado", db_estado, 5);
    chk("fj_pronto", pronto, 0);
    chk("fj_vencedor", vencedor, 2'b10);
    iniciar = 1'b1;
    ciclo;
    iniciar = 1'b0;
    ciclo;
    chk("fj_iniciar_ignorado", db_estado, 5);
    chk("fj_vivos", vivos, 5'b00101);
    alvo = 3'd0;
    confirma = 1'b1;
    ciclo;
    confirma = 1'b0;
    chk("fj_confirma_sem_erro", erro, 0);
    // doctor saves
    rst;
    chk("rst2_vivos", vivos, 5'b11111);
    chk("rst2_estado", db_estado, 0);
    chk("rst2_vencedor", vencedor, 0);
    noite(4, 1'b1);
    esperar_fim(3);
    // village wins: wolf targets itself
    noite(5, 1'b1);
    esperar_fim(3);
    chk("vila_estado", db_estado, 5);
    // reset mid-night during P2's turn
    rst;
    noite(6, 1'b0);
    for (int w = 0; w < 10 && !aguardando; w++) ciclo;
    chk("mid_jogador", jogador_atual, 2);
    chk("mid_espera", aguardando, 1);
    reset = 1'b1;
    ciclo;
    reset = 1'b0;
    chk("mid_estado", db_estado, 0);
    chk("mid_vivos", vivos, 5'b11111);
    chk("mid_revela_valida", revela_valida, 0);
    chk("mid_pronto", pronto, 1);
    chk("mid_aguardando", aguardando, 0);
    ciclo;
    chk("pulsos_fim", pulsos, 5);
    chk("fila_vazia", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
